// File: rtl/fetch_memory_pkg.sv
// Shared constants and types for the instruction fetch memory.
// Holds the NOP encoding used for the clear sweep, the FSM state type and the parameter defaults.
package fetch_memory_pkg;

  localparam int unsigned DEF_DEPTH_WORDS    = 256;
  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_WORD_W         = 32;
  localparam bit          DEF_CLEAR_ON_RESET = 1'b1;

  // ARM "AND R0,R0,R0": executes as a no-op.
  localparam logic [31:0] NOP_INSTR = 32'hE000_0000;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

endpackage

// File: rtl/fetch_memory_byte_lane_ram.sv
// Word-organised RAM with per-byte write enables and one registered read port.
// Lane LANES-1 is the most significant byte; a same-edge read returns the pre-write word.
module byte_lane_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LANES = 4,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [LANES*8-1:0]   wdata,
  input  logic [LANES-1:0]     be,
  input  logic                 re,
  input  logic [IDX_W-1:0]     raddr,
  output logic [LANES*8-1:0]   rdata
);

  logic [LANES-1:0][7:0] mem_q [DEPTH];
  logic [LANES*8-1:0]    rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (be[l]) begin
          mem_q[waddr][l] <= wdata[l*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fetch_memory.sv
// Instruction fetch memory: one-cycle fetch port, byte-enabled program port,
// range/alignment checking and an optional NOP clear sweep after reset or on request.
module fetch_memory
  import fetch_memory_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = DEF_DEPTH_WORDS,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned WORD_W         = DEF_WORD_W,
  parameter bit          CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_W-1:0]     fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [WORD_W-1:0]     fetch_data,
  output logic                  fetch_err,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [WORD_W-1:0]     prog_wdata,
  input  logic [WORD_W/8-1:0]   prog_be,
  output logic                  prog_err,
  input  logic                  clear_req,
  output logic                  busy
);

  localparam int unsigned LANES = WORD_W / 8;
  localparam int unsigned LSB   = $clog2(LANES);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               prog_err_q, prog_err_d;
  logic [WORD_W-1:0]  hold_q;

  logic               f_ok, p_ok, accept;
  logic [IDX_W-1:0]   f_idx, p_idx;

  logic               ram_we, ram_re;
  logic [IDX_W-1:0]   ram_waddr;
  logic [WORD_W-1:0]  ram_wdata, ram_rdata;
  logic [LANES-1:0]   ram_be;

  // Every address bit above the index must be zero, so out-of-range addresses never alias.
  always_comb begin
    f_ok  = ((fetch_addr & ADDR_W'(LANES - 1)) == '0) &&
            ((fetch_addr >> (LSB + IDX_W)) == '0);
    p_ok  = ((prog_addr & ADDR_W'(LANES - 1)) == '0) &&
            ((prog_addr >> (LSB + IDX_W)) == '0);
    f_idx = fetch_addr[LSB +: IDX_W];
    p_idx = prog_addr[LSB +: IDX_W];
  end

  assign accept = fetch_req && (state_q == ST_READY) && !rst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    prog_err_d = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = cnt_q;
    ram_wdata  = WORD_W'(NOP_INSTR);
    ram_be     = '1;
    ram_re     = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (!rst) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (accept) begin
          valid_d = 1'b1;
          err_d   = !f_ok;
          ram_re  = f_ok;
        end
        if (prog_we && !rst) begin
          if (p_ok) begin
            ram_we    = 1'b1;
            ram_waddr = p_idx;
            ram_wdata = prog_wdata;
            ram_be    = prog_be;
          end else begin
            prog_err_d = 1'b1;
          end
        end
        if (clear_req && CLEAR_ON_RESET) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      prog_err_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      prog_err_q <= prog_err_d;
      hold_q     <= fetch_data;
    end
  end

  byte_lane_ram #(
    .DEPTH (DEPTH_WORDS),
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .re    (ram_re),
    .raddr (f_idx),
    .rdata (ram_rdata)
  );

  // The RAM read register feeds the output during the pulse; hold_q keeps it afterwards.
  always_comb begin
    if (valid_q) begin
      fetch_data = err_q ? WORD_W'(NOP_INSTR) : ram_rdata;
    end else begin
      fetch_data = hold_q;
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_err   = valid_q & err_q;
  assign prog_err    = prog_err_q;
  assign busy        = (state_q == ST_INIT);
  assign fetch_ready = (state_q == ST_READY);

endmodule

// File: tb/tb_fetch_memory.sv
// Bench for fetch_memory (DEPTH_WORDS=16): directed vector table, randomized traffic
// against a byte-addressed reference memory, and clear/reset sweep sequences.
module tb_fetch_memory;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic [3:0]  prog_be;
  logic        prog_err;
  logic        clear_req;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  logic [31:0] mem_m [16];
  logic [31:0] last_data;

  typedef struct {
    int          kind;      // 0 fetch, 1 write, 2 fetch+write same cycle
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_perr;
  } vec_t;

  vec_t tbl [13];

  fetch_memory #(
    .DEPTH_WORDS    (16),
    .ADDR_W         (32),
    .WORD_W         (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .prog_be     (prog_be),
    .prog_err    (prog_err),
    .clear_req   (clear_req),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < 16);
  endfunction

  // Byte at address a+k is the k-th most significant byte; be bit 3-k enables it.
  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int k = 0; k < 4; k++) begin
      if (be[3-k]) mem_m[a/4][31-8*k -: 8] = d[31-8*k -: 8];
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) mem_m[i] = NOP;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    if (sel <= 6)      a = 32'($urandom_range(0, 15)) * 4;
    else if (sel == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
    else if (sel == 8) a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
    else               a = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
    return a;
  endfunction

  // Drive stray traffic through the sweep, count cycles with busy high after reset/clear.
  task automatic sweep_count(output int n);
    n = 0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    prog_we    = 1'b1;
    prog_addr  = 32'h0;
    prog_wdata = 32'h0BAD_F00D;
    prog_be    = 4'hF;
    clear_req  = 1'b1;
    while (busy && n < 100) begin
      step();
      n++;
      chk("init_no_valid", fetch_valid, 0);
      chk("init_no_prog_err", prog_err, 0);
    end
    fetch_req = 1'b0;
    prog_we   = 1'b0;
    clear_req = 1'b0;
    m_clear();
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    chk("fetch_valid", fetch_valid, 1);
    chk("fetch_data", fetch_data, exp_d);
    chk("fetch_err", fetch_err, exp_e);
    last_data = exp_d;
  endtask

  initial begin
    int n;
    logic fr, pw;
    logic [31:0] fa, pa, pwd, exp_fd;
    logic [3:0] pbe;
    logic exp_fe, exp_pe;

    tbl[0]  = '{0, 32'h0000_003C, 32'h0,          4'h0, NOP,          1'b0, 1'b0};
    tbl[1]  = '{1, 32'h0000_0004, 32'hE3A0_0014, 4'hF, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1, 32'h0000_0004, 32'h0000_00FF, 4'h1, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{0, 32'h0000_0004, 32'h0,          4'h0, 32'hE3A0_00FF, 1'b0, 1'b0};
    tbl[4]  = '{0, 32'h0000_0006, 32'h0,          4'h0, NOP,          1'b1, 1'b0};
    tbl[5]  = '{0, 32'h0000_0040, 32'h0,          4'h0, NOP,          1'b1, 1'b0};
    tbl[6]  = '{1, 32'h0000_0041, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b0, 1'b1};
    tbl[7]  = '{0, 32'h0000_0000, 32'h0,          4'h0, NOP,          1'b0, 1'b0};
    tbl[8]  = '{2, 32'h0000_0008, 32'h1234_5678, 4'hF, NOP,          1'b0, 1'b0};
    tbl[9]  = '{0, 32'h0000_0008, 32'h0,          4'h0, 32'h1234_5678, 1'b0, 1'b0};
    tbl[10] = '{1, 32'h0000_000A, 32'hCAFE_CAFE, 4'hF, 32'h0,        1'b0, 1'b1};
    tbl[11] = '{0, 32'h0000_0008, 32'h0,          4'h0, 32'h1234_5678, 1'b0, 1'b0};
    tbl[12] = '{0, 32'h1000_0004, 32'h0,          4'h0, NOP,          1'b1, 1'b0};

    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; prog_we = 1'b0;
    prog_addr = '0; prog_wdata = '0; prog_be = '0; clear_req = 1'b0;
    last_data = '0;

    repeat (3) step();
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_err", fetch_err, 0);
    chk("rst_prog_err", prog_err, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", fetch_ready, 0);

    rst = 1'b0;
    sweep_count(n);
    chk("sweep_cycles", n, 16);
    chk("ready_after_sweep", fetch_ready, 1);

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      fetch_req  = (tbl[i].kind != 1);
      fetch_addr = tbl[i].addr;
      prog_we    = (tbl[i].kind != 0);
      prog_addr  = tbl[i].addr;
      prog_wdata = tbl[i].wdata;
      prog_be    = tbl[i].be;
      step();
      fetch_req = 1'b0;
      prog_we   = 1'b0;
      chk("vec_valid", fetch_valid, (tbl[i].kind != 1));
      if (tbl[i].kind != 1) begin
        chk("vec_data", fetch_data, tbl[i].exp_data);
        chk("vec_err", fetch_err, tbl[i].exp_err);
        last_data = tbl[i].exp_data;
      end
      chk("vec_prog_err", prog_err, tbl[i].exp_perr);
      if (tbl[i].kind != 0 && m_ok(tbl[i].addr)) m_write(tbl[i].addr, tbl[i].wdata, tbl[i].be);
      step();
      chk("vec_idle_valid", fetch_valid, 0);
      chk("vec_hold_data", fetch_data, last_data);
      chk("vec_idle_prog_err", prog_err, 0);
    end

    // Randomized traffic against the reference memory
    for (int i = 0; i < 400; i++) begin
      fr  = 1'($urandom_range(0, 1));
      pw  = ($urandom_range(0, 2) == 0);
      fa  = rand_addr();
      pa  = rand_addr();
      pwd = $urandom;
      pbe = 4'($urandom_range(0, 15));
      exp_fe = !m_ok(fa);
      exp_fd = exp_fe ? NOP : mem_m[fa/4];
      exp_pe = pw && !m_ok(pa);
      fetch_req = fr; fetch_addr = fa;
      prog_we = pw; prog_addr = pa; prog_wdata = pwd; prog_be = pbe;
      step();
      if (pw && m_ok(pa)) m_write(pa, pwd, pbe);
      chk("rnd_valid", fetch_valid, fr);
      if (fr) begin
        chk("rnd_data", fetch_data, exp_fd);
        chk("rnd_err", fetch_err, exp_fe);
        last_data = exp_fd;
      end else begin
        chk("rnd_hold", fetch_data, last_data);
      end
      chk("rnd_prog_err", prog_err, exp_pe);
    end
    fetch_req = 1'b0;
    prog_we   = 1'b0;
    step();

    // Back-to-back fetches, clear alongside the third, then reset mid-sweep
    fetch_req = 1'b1;
    fetch_addr = 32'h0;
    step();
    chk("b2b0_valid", fetch_valid, 1);
    chk("b2b0_data", fetch_data, mem_m[0]);
    fetch_addr = 32'h4;
    step();
    chk("b2b1_valid", fetch_valid, 1);
    chk("b2b1_data", fetch_data, mem_m[1]);
    fetch_addr = 32'h8;
    clear_req  = 1'b1;
    step();
    fetch_req = 1'b0;
    clear_req = 1'b0;
    chk("b2b2_valid", fetch_valid, 1);
    chk("b2b2_data", fetch_data, mem_m[2]);
    chk("clear_busy", busy, 1);
    repeat (5) step();
    chk("mid_sweep_busy", busy, 1);
    rst = 1'b1;
    repeat (2) step();
    chk("rst2_busy", busy, 1);
    chk("rst2_fetch_data", fetch_data, 0);
    rst = 1'b0;
    sweep_count(n);
    chk("restart_sweep_cycles", n, 16);
    for (int w = 0; w < 16; w++) begin
      do_fetch(32'(w * 4), NOP, 1'b0);
    end
    step();

    // Reset in the same cycle as a fetch request
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    rst        = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("rst_fetch_suppressed", fetch_valid, 0);
    chk("rst_fetch_data_zero", fetch_data, 0);
    rst = 1'b0;
    sweep_count(n);
    chk("final_sweep_cycles", n, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fetch_memory.md
FETCH_MEMORY -- requirements
Module: fetch_memory

Interface
REQ-001 Parameter DEPTH_WORDS, 256, number of instruction words stored (power of two, minimum 4).
REQ-002 Parameter ADDR_W, 32, byte-address width of the fetch and program ports.
REQ-003 Parameter WORD_W, 32, instruction width (multiple of 8; LANES = WORD_W/8).
REQ-004 Parameter CLEAR_ON_RESET, 1, 1 selects a sweep that writes NOP to every word after reset; 0 selects immediate READY.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 fetch_req  in  1  fetch request; accepted when fetch_ready=1.
REQ-008 fetch_addr  in  ADDR_W  byte address of the requested word.
REQ-009 fetch_ready  out  1  block is in READY state.
REQ-010 fetch_valid  out  1  one-cycle pulse; fetch_data/fetch_err are valid.
REQ-011 fetch_data  out  WORD_W  fetched instruction, big-endian (byte at addr+0 is most significant).
REQ-012 fetch_err  out  1  the accepted fetch was misaligned or out of range.
REQ-013 prog_we  in  1  program-port write strobe.
REQ-014 prog_addr  in  ADDR_W  byte address of the word being written.
REQ-015 prog_wdata  in  WORD_W  write data, same big-endian byte order as fetch_data.
REQ-016 prog_be  in  LANES  byte enables; bit LANES-1 selects the byte at addr+0.
REQ-017 prog_err  out  1  one-cycle pulse; the last write was rejected.
REQ-018 clear_req  in  1  in READY, restarts the NOP sweep (ignored if CLEAR_ON_RESET=0).
REQ-019 busy  out  1  sweep in progress.

Function
REQ-020 The FSM SHALL have the states INIT and READY. Reset enters INIT if CLEAR_ON_RESET=1 and READY otherwise.
REQ-021 In INIT, the sweep counter SHALL write NOP_INSTR to word 0..DEPTH_WORDS-1, one word per cycle. After the last word the FSM SHALL enter READY, so INIT lasts exactly DEPTH_WORDS cycles.
REQ-022 In INIT, fetch_req, prog_we and clear_req SHALL be ignored. No fetch_valid or prog_err SHALL be produced.
REQ-023 clear_req in READY SHALL enter INIT on the next cycle with the counter at 0. A fetch accepted in the same cycle SHALL still complete.
REQ-024 A fetch SHALL be accepted when fetch_req=1 and fetch_ready=1. fetch_valid SHALL assert exactly one cycle later (latency 1, throughput one fetch per cycle).
REQ-025 fetch_data SHALL hold its value between pulses. It SHALL change only when fetch_valid asserts.
REQ-026 A fetch is faulty if fetch_addr[log2(LANES)-1:0] is not 0 or the word index is at least DEPTH_WORDS. A faulty fetch SHALL return fetch_err=1 with fetch_data=NOP_INSTR, and SHALL NOT index the array.
REQ-027 A program write in READY SHALL update only the byte lanes enabled by prog_be, on the same edge.
REQ-028 A program write whose address fails the REQ-026 check SHALL NOT modify memory. prog_err SHALL pulse in the next cycle.
REQ-029 When a fetch and a write target the same word in the same cycle, the fetch SHALL return the pre-write contents (read-before-write).
REQ-030 Word index = fetch_addr >> log2(LANES). Address bits above log2(DEPTH_WORDS)+log2(LANES) SHALL only feed the range check; there SHALL be no wrap-around aliasing.

Reset
REQ-031 While rst=1: fetch_valid=0, fetch_err=0, prog_err=0, fetch_data=0, and the sweep counter is 0.
REQ-032 While rst=1, busy=1 and fetch_ready=0 if CLEAR_ON_RESET=1; otherwise busy=0 and fetch_ready=1 from the first cycle after reset.
REQ-033 Reset during INIT SHALL restart the sweep from word 0.
REQ-034 Reset during a fetch SHALL suppress that fetch's fetch_valid.
REQ-035 Memory contents SHALL NOT be altered by reset itself, only by the sweep.

Structure
REQ-036 A shared package SHALL hold NOP_INSTR (32'hE0000000, the ARM AND R0,R0,R0 encoding), the INIT/READY state typedef, and the default parameter values.
REQ-037 Storage SHALL be the sub-module byte_lane_ram: one synchronous write port with byte enables and one registered read port, instantiated once with LANES lanes. The FSM, range check and output registers live in fetch_memory.

Verification
REQ-038 Reset with DEPTH_WORDS=16, then fetch address 0x3C -> busy high for exactly 16 cycles, then fetch_data=0xE0000000, fetch_err=0.
REQ-039 Write 0xE3A00014 to 0x04 with prog_be=4'b1111, then write 0xFF to 0x04 with prog_be=4'b0001 -> fetch at 0x04 returns 0xE3A000FF.
REQ-040 Fetch 0x06 and fetch 0x40 (DEPTH_WORDS=16) -> fetch_err=1, fetch_data=0xE0000000; prog_we to 0x41 -> prog_err pulse, memory unchanged.
REQ-041 Same-cycle write of 0x12345678 and fetch at 0x08 (old value 0xE0000000) -> this fetch returns 0xE0000000, the next fetch returns 0x12345678.
REQ-042 Back-to-back fetches 0x00, 0x04, 0x08, then clear_req, then rst asserted mid-sweep -> three consecutive fetch_valid pulses; the sweep restarts at word 0; all words read 0xE0000000 afterwards.
